// File: rtl/assoc_wb_cache.sv
// assoc_wb_cache: set-associative, write-back, write-allocate data cache.
// Hits complete one cycle after acceptance. Misses move whole lines over a
// req/ack memory port. A dirty victim is written back before the fill, and
// mem_req drops for a cycle between the two transactions.
// Optional build macro ASSOC_CACHE_STATS_EN adds saturating hit/miss/writeback
// counters as extra outputs.

module assoc_wb_cache_way_cmp #(
  parameter int TAG_W = 20
) (
  input  logic             vld,
  input  logic [TAG_W-1:0] tag,
  input  logic [TAG_W-1:0] ref_tag,
  output logic             hit
);
  assign hit = vld && (tag == ref_tag);
endmodule

module assoc_wb_cache #(
  parameter int WAYS           = 2,
  parameter int SETS           = 256,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [31:0]                  cpu_addr,
  input  logic [31:0]                  cpu_wdata,
  input  logic [3:0]                   cpu_be,
  output logic                         cpu_ready,
  output logic [31:0]                  cpu_rdata,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [31:0]                  mem_addr,
  output logic [32*WORDS_PER_LINE-1:0] mem_wdata,
  input  logic [32*WORDS_PER_LINE-1:0] mem_rdata,
  input  logic                         mem_ack
`ifdef ASSOC_CACHE_STATS_EN
  ,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count,
  output logic [31:0]                  wb_count
`endif
);
  localparam int OFF_W  = $clog2(WORDS_PER_LINE) + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int LINE_W = 32 * WORDS_PER_LINE;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WRD_W  = (OFF_W > 2) ? OFF_W - 2 : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, FILL} state_t;
  state_t state;

  // Per way/set state; tag and data arrays carry no reset
  logic [SETS-1:0][WAYS-1:0]  valid_q, dirty_q;
  logic [SETS-1:0][WAY_W-1:0] ptr_q;
  logic [TAG_W-1:0]           tag_q  [WAYS][SETS];
  logic [LINE_W-1:0]          data_q [WAYS][SETS];

  // Latched request
  logic [31:2] rq_addr;
  logic        rq_we;
  logic [31:0] rq_wdata;
  logic [3:0]  rq_be;
  logic        first_q;
  logic [WAY_W-1:0] vic_q;
  logic        vic_ptr_q;

  logic [TAG_W-1:0] rq_tag;
  logic [IDX_W-1:0] rq_idx;
  logic [WRD_W-1:0] rq_wrd;
  logic [1:0]       unused_addr;

  assign rq_tag      = rq_addr[31:IDX_W+OFF_W];
  assign rq_idx      = rq_addr[IDX_W+OFF_W-1:OFF_W];
  assign unused_addr = cpu_addr[1:0];

  generate
    if (OFF_W > 2) begin : g_wrd
      assign rq_wrd = rq_addr[OFF_W-1:2];
    end else begin : g_wrd1
      assign rq_wrd = '0;
    end
  endgenerate

  // Per-way tag comparators on the indexed set
  logic [WAYS-1:0]             way_hit;
  logic [WAYS-1:0][TAG_W-1:0]  set_tag;
  logic [WAYS-1:0][LINE_W-1:0] set_line;

  generate
    for (genvar w = 0; w < WAYS; w++) begin : g_way
      assign set_tag[w]  = tag_q[w][rq_idx];
      assign set_line[w] = data_q[w][rq_idx];
      assoc_wb_cache_way_cmp #(.TAG_W(TAG_W)) u_cmp (
        .vld     (valid_q[rq_idx][w]),
        .tag     (set_tag[w]),
        .ref_tag (rq_tag),
        .hit     (way_hit[w])
      );
    end
  endgenerate

  // Lowest hitting way, lowest invalid way, victim, and the store-merged line
  logic             hit_any, inv_any;
  logic [WAY_W-1:0] hit_way, inv_way, vic_way;
  logic [LINE_W-1:0] hit_line, merged_line;
  logic [31:0]       hit_word;
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[rq_idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    vic_way     = inv_any ? inv_way : ptr_q[rq_idx];
    hit_line    = set_line[hit_way];
    hit_word    = hit_line[32*rq_wrd +: 32];
    merged_line = hit_line;
    for (int b = 0; b < 4; b++)
      if (rq_be[b]) merged_line[32*rq_wrd + 8*b +: 8] = rq_wdata[8*b +: 8];
  end

  // Array write port: store-hit merge or line fill
  logic              line_we, tag_we;
  logic [WAY_W-1:0]  line_way;
  logic [LINE_W-1:0] line_din;
  always_comb begin
    tag_we   = rst_b && (state == FILL) && mem_req && mem_ack;
    line_we  = tag_we || (rst_b && (state == LOOKUP) && hit_any && rq_we);
    line_way = (state == FILL) ? vic_q : hit_way;
    line_din = (state == FILL) ? mem_rdata : merged_line;
  end

  // Tag/data storage update
  always_ff @(posedge clk) begin
    if (line_we) data_q[line_way][rq_idx] <= line_din;
    if (tag_we)  tag_q[vic_q][rq_idx]     <= rq_tag;
  end

  // Control FSM with registered CPU/memory outputs
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state     <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      ptr_q     <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rq_addr   <= '0;
      rq_we     <= 1'b0;
      rq_wdata  <= '0;
      rq_be     <= '0;
      first_q   <= 1'b0;
      vic_q     <= '0;
      vic_ptr_q <= 1'b0;
`ifdef ASSOC_CACHE_STATS_EN
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
`endif
    end else begin
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      case (state)
        IDLE: if (cpu_req) begin
          rq_addr  <= cpu_addr[31:2];
          rq_we    <= cpu_we;
          rq_wdata <= cpu_wdata;
          rq_be    <= cpu_be;
          first_q  <= 1'b1;
          state    <= LOOKUP;
        end
        LOOKUP: if (hit_any) begin
          cpu_ready <= 1'b1;
          if (rq_we) dirty_q[rq_idx][hit_way] <= 1'b1;
          else       cpu_rdata <= hit_word;
`ifdef ASSOC_CACHE_STATS_EN
          if (first_q && hit_count != '1) hit_count <= hit_count + 1'b1;
`endif
          state <= IDLE;
        end else begin
          vic_q     <= vic_way;
          vic_ptr_q <= !inv_any;
          first_q   <= 1'b0;
          mem_req   <= 1'b1;
`ifdef ASSOC_CACHE_STATS_EN
          if (miss_count != '1) miss_count <= miss_count + 1'b1;
`endif
          if (valid_q[rq_idx][vic_way] && dirty_q[rq_idx][vic_way]) begin
            mem_we    <= 1'b1;
            mem_addr  <= {set_tag[vic_way], rq_idx, {OFF_W{1'b0}}};
            mem_wdata <= set_line[vic_way];
            state     <= WRITEBACK;
          end else begin
            mem_we   <= 1'b0;
            mem_addr <= {rq_tag, rq_idx, {OFF_W{1'b0}}};
            state    <= FILL;
          end
        end
        WRITEBACK: if (mem_req && mem_ack) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          dirty_q[rq_idx][vic_q] <= 1'b0;
`ifdef ASSOC_CACHE_STATS_EN
          if (wb_count != '1) wb_count <= wb_count + 1'b1;
`endif
          state <= FILL;
        end
        FILL: if (!mem_req) begin
          // Re-raise after the idle cycle that follows a writeback
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= {rq_tag, rq_idx, {OFF_W{1'b0}}};
        end else if (mem_ack) begin
          mem_req <= 1'b0;
          valid_q[rq_idx][vic_q] <= 1'b1;
          dirty_q[rq_idx][vic_q] <= 1'b0;
          if (vic_ptr_q)
            ptr_q[rq_idx] <= (WAYS == 1) ? '0 : ptr_q[rq_idx] + 1'b1;
          state <= LOOKUP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_assoc_wb_cache.sv
// Bench for assoc_wb_cache (WAYS=2, SETS=4, WORDS_PER_LINE=4): directed
// vector table, reset-during-fill sequence, then random traffic checked
// against a flat-memory golden model plus a tag/replacement model.
module tb_assoc_wb_cache;
  localparam int WAYS = 2, SETS = 4, WPL = 4, LW = 32 * WPL;

  logic clk = 0, rst_b = 0;
  logic cpu_req = 0, cpu_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic [3:0]  cpu_be = 0;
  logic        cpu_ready, mem_req, mem_we;
  logic [31:0] cpu_rdata, mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata = '0;
  logic        mem_ack = 0;
`ifdef ASSOC_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  assoc_wb_cache #(.WAYS(WAYS), .SETS(SETS), .WORDS_PER_LINE(WPL)) dut (
    .clk(clk), .rst_b(rst_b), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef ASSOC_CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Main memory behind the cache, and the value the CPU should observe
  logic [31:0] mem_store [logic [31:0]];
  logic [31:0] gold      [logic [31:0]];
  function automatic logic [31:0] init_word(logic [31:0] a);
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction
  function automatic logic [31:0] mem_get(logic [31:0] a);
    return mem_store.exists(a) ? mem_store[a] : init_word(a);
  endfunction
  function automatic logic [31:0] gold_get(logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_word(a);
  endfunction

  // Cache-content model: which tags are resident, dirty, and round-robin pointer
  bit          mv [SETS][WAYS];
  bit          md [SETS][WAYS];
  logic [25:0] mt [SETS][WAYS];
  int          mp [SETS];

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      mp[s] = 0;
      for (int w = 0; w < WAYS; w++) begin mv[s][w] = 0; md[s][w] = 0; end
    end
    gold.delete();
    foreach (mem_store[k]) gold[k] = mem_store[k];
  endtask

  // Memory responder; records each transaction it serves
  bit          auto_mem = 1;
  bit          tq_we   [$];
  logic [31:0] tq_addr [$];
  logic [LW-1:0] tq_line [$];
  logic [31:0] r_addr;
  logic [LW-1:0] r_line;
  int          r_dly;
  initial forever begin
    @(posedge clk); #1;
    if (auto_mem && rst_b && mem_req) begin
      r_addr = mem_addr;
      tq_we.push_back(mem_we); tq_addr.push_back(r_addr); tq_line.push_back(mem_wdata);
      if (mem_we) for (int k = 0; k < WPL; k++) mem_store[r_addr + 4*k] = mem_wdata[32*k +: 32];
      for (int k = 0; k < WPL; k++) r_line[32*k +: 32] = mem_get(r_addr + 4*k);
      r_dly = $urandom_range(0, 2);
      repeat (r_dly) begin @(posedge clk); #1; end
      chk("mem_addr_stable", mem_addr, r_addr);
      mem_rdata = r_line; mem_ack = 1;
      @(posedge clk); #1;
      mem_ack = 0; mem_rdata = '0;
      chk("mem_req_drop", 32'(mem_req), 0);
    end
  end

  task automatic do_reset();
    rst_b = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst_b = 1;
    model_reset();
  endtask

  // One CPU access, predicted by the model and checked on completion
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output bit missed,
                        output bit wbk, output logic [31:0] wba, output logic [31:0] wbw0);
    int s, hw, vic, cyc, last;
    bit fp, e_wb;
    logic [31:0] e_wba, e_rd, wa, old;
    s = int'(a[5:4]); wa = {a[31:2], 2'b00};
    hw = -1;
    for (int w = WAYS - 1; w >= 0; w--) if (mv[s][w] && mt[s][w] == a[31:6]) hw = w;
    e_wb = 0; e_wba = 0; vic = 0; fp = 0;
    if (hw < 0) begin
      vic = -1;
      for (int w = WAYS - 1; w >= 0; w--) if (!mv[s][w]) vic = w;
      fp = (vic < 0);
      if (fp) vic = mp[s];
      e_wb  = mv[s][vic] && md[s][vic];
      e_wba = {mt[s][vic], a[5:4], 4'h0};
    end
    e_rd = we ? 32'h0 : gold_get(wa);
    tq_we.delete(); tq_addr.delete(); tq_line.delete();
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_be = be;
    @(posedge clk); #1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 0;
    cyc = 0;
    while (!cpu_ready && cyc < 200) begin @(posedge clk); #1; cyc++; end
    chk("cpu_ready_seen", 32'(cpu_ready), 1);
    rd = cpu_rdata;
    chk(we ? "store_rdata" : "load_rdata", rd, e_rd);
    if (hw >= 0) chk("hit_latency", 32'(cyc), 1);
    chk("txn_count", 32'(tq_we.size()), 32'(int'(hw < 0) + int'(e_wb)));
    missed = 0; wbk = 0; wba = 0; wbw0 = 0;
    foreach (tq_we[k])
      if (tq_we[k]) begin wbk = 1; wba = tq_addr[k]; wbw0 = tq_line[k][31:0]; end
      else missed = 1;
    if (hw < 0 && tq_we.size() == int'(e_wb) + 1) begin
      last = tq_we.size() - 1;
      chk("fill_we", 32'(tq_we[last]), 0);
      chk("fill_addr", tq_addr[last], {a[31:4], 4'h0});
      if (e_wb) begin
        chk("wb_we", 32'(tq_we[0]), 1);
        chk("wb_addr", tq_addr[0], e_wba);
        for (int k = 0; k < WPL; k++) chk("wb_data", tq_line[0][32*k +: 32], gold_get(e_wba + 4*k));
      end
    end
    if (hw < 0) begin
      mv[s][vic] = 1; md[s][vic] = 0; mt[s][vic] = a[31:6];
      if (fp) mp[s] = (mp[s] + 1) % WAYS;
      hw = vic;
    end
    if (we) begin
      md[s][hw] = 1;
      old = gold_get(wa);
      for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
      gold[wa] = old;
    end
  endtask

  typedef struct {
    bit rst; bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;
    logic [31:0] exp_rd; bit exp_miss; bit exp_wb; logic [31:0] exp_wba; logic [31:0] exp_w0;
  } vec_t;
  vec_t vecs [13];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, wba, w0;
    bit ms, wb;
    vecs[0]  = '{0, 0, 32'h104, 0, 4'h0, 32'hA1, 1, 0, 0, 0};
    vecs[1]  = '{0, 0, 32'h10C, 0, 4'h0, 32'hA3, 0, 0, 0, 0};
    vecs[2]  = '{0, 1, 32'h100, 32'h11223344, 4'hF, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 1, 32'h100, 32'hAABBCCDD, 4'h3, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 32'h100, 0, 4'h0, 32'h1122CCDD, 0, 0, 0, 0};
    vecs[5]  = '{1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0};
    vecs[6]  = '{0, 1, 32'h000, 32'hDEADBEEF, 4'hF, 0, 1, 0, 0, 0};
    vecs[7]  = '{0, 0, 32'h040, 0, 4'h0, 32'hC0DE0040, 1, 0, 0, 0};
    vecs[8]  = '{0, 0, 32'h080, 0, 4'h0, 32'hC0DE0080, 1, 1, 32'h000, 32'hDEADBEEF};
    vecs[9]  = '{0, 0, 32'h0C0, 0, 4'h0, 32'hC0DE00C0, 1, 0, 0, 0};
    vecs[10] = '{0, 0, 32'h084, 0, 4'h0, 32'hC0DE0084, 0, 0, 0, 0};
    vecs[11] = '{0, 0, 32'h000, 0, 4'h0, 32'hDEADBEEF, 1, 0, 0, 0};
    vecs[12] = '{0, 0, 32'h0C4, 0, 4'h0, 32'hC0DE00C4, 0, 0, 0, 0};
    for (int k = 0; k < 4; k++) mem_store[32'h100 + 4*k] = 32'hA0 + k;

    // Reset state
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_cpu_ready", 32'(cpu_ready), 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata[31:0], 0);
`ifdef ASSOC_CACHE_STATS_EN
    chk("rst_hit_count", hit_count, 0);
`endif
    rst_b = 1;
    model_reset();

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst) do_reset();
      else begin
        access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, ms, wb, wba, w0);
        chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        chk($sformatf("vec%0d_miss", i), 32'(ms), 32'(vecs[i].exp_miss));
        chk($sformatf("vec%0d_wb", i), 32'(wb), 32'(vecs[i].exp_wb));
        if (vecs[i].exp_wb) begin
          chk($sformatf("vec%0d_wb_addr", i), wba, vecs[i].exp_wba);
          chk($sformatf("vec%0d_wb_w0", i), w0, vecs[i].exp_w0);
        end
`ifdef ASSOC_CACHE_STATS_EN
        if (i == 8) begin
          chk("stats_hit", hit_count, 0);
          chk("stats_miss", miss_count, 3);
          chk("stats_wb", wb_count, 1);
        end
`endif
      end
    end

    // Reset while a fill is outstanding; a late ack must be ignored
    do_reset();
    auto_mem = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    @(posedge clk); #1;
    cpu_req = 0; cpu_addr = 0;
    for (int c = 0; c < 10 && !mem_req; c++) begin @(posedge clk); #1; end
    chk("rif_mem_req", 32'(mem_req), 1);
    chk("rif_mem_addr", mem_addr, 32'h100);
    chk("rif_mem_we", 32'(mem_we), 0);
    rst_b = 0;
    @(posedge clk); #1;
    chk("rif_req_dropped", 32'(mem_req), 0);
    rst_b = 1;
    mem_rdata = {WPL{32'hBAD0BAD0}}; mem_ack = 1;
    @(posedge clk); #1;
    mem_ack = 0; mem_rdata = '0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rif_late_ack_req", 32'(mem_req), 0);
    chk("rif_late_ack_ready", 32'(cpu_ready), 0);
    model_reset();
    auto_mem = 1;
    access(0, 32'h100, 0, 4'h0, rd, ms, wb, wba, w0);
    chk("rif_reload_miss", 32'(ms), 1);
    chk("rif_reload_data", rd, 32'hA0);

    // Random traffic over 8 tags per set
    for (int i = 0; i < 400; i++)
      access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 127)) << 2, $urandom,
             4'($urandom_range(0, 15)), rd, ms, wb, wba, w0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/assoc_wb_cache.md
Name: assoc_wb_cache

Overview:
- Parametrised set-associative, write-back, write-allocate data cache between the load/store stage and main memory.
- Replaces the single-word direct-mapped cache, adding:
  - multi-word lines and configurable ways/sets;
  - round-robin replacement;
  - an explicit FSM with a req/ack memory handshake.
- The CPU side sees a simple request/ready protocol. The memory side moves whole lines per transaction.

Parameters:
- WAYS, 2, ways per set (power of two, 1..8)
- SETS, 256, sets (power of two, >=2)
- WORDS_PER_LINE, 4, 32-bit words per line (power of two, 1..16)
- Derived, not overridable:
  - OFF_W = log2(WORDS_PER_LINE)+2
  - IDX_W = log2(SETS)
  - TAG_W = 32-IDX_W-OFF_W
  - LINE_W = 32*WORDS_PER_LINE

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_b  in  1  synchronous active-low reset
- cpu_req  in  1  access request, sampled only in IDLE
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address; bits [1:0] ignored
- cpu_wdata  in  32  store data
- cpu_be  in  4  store byte enables, bit i covers byte i
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  load data, valid while cpu_ready=1
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = line writeback, 0 = line fill
- mem_addr  out  32  line-aligned address (low OFF_W bits zero)
- mem_wdata  out  LINE_W  writeback line, word 0 in bits [31:0]
- mem_rdata  in  LINE_W  fill line, valid when mem_ack=1
- mem_ack  in  1  one-cycle completion of the current transaction

Behaviour:
- Address split: tag=[31:IDX_W+OFF_W], index=[IDX_W+OFF_W-1:OFF_W], word=[OFF_W-1:2].
- Per way and set: valid, dirty, tag, line. Per set: round-robin victim pointer.
- Reset (rst_b=0 at an edge):
  - clears all valid, dirty and victim pointers; state=IDLE;
  - cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata all 0;
  - tag/data arrays need not be cleared;
  - reset mid-transaction: mem_req is 0 from the next cycle, the transaction is abandoned, and a late mem_ack is ignored.
- FSM states: IDLE, LOOKUP, WRITEBACK, FILL.
- IDLE:
  - if cpu_req=1, latch addr/we/wdata/be and go to LOOKUP;
  - CPU inputs are ignored outside IDLE.
- LOOKUP, all ways compared in parallel:
  - Hit, load: cpu_ready=1 and cpu_rdata=selected word in this same cycle, then go to IDLE.
  - Hit, store: merge enabled bytes into the word, set dirty, cpu_ready=1 (cpu_rdata=0), then go to IDLE.
  - Hit latency: cpu_ready is high exactly 1 cycle after acceptance; the next request can be accepted 1 cycle later.
  - Miss, victim choice: lowest-index invalid way; if none, the way at the set pointer.
  - Miss, next state: victim valid and dirty goes to WRITEBACK, otherwise FILL.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata=victim line;
  - outputs held stable until mem_ack;
  - on mem_ack: mem_req=0 next cycle, clear victim dirty, go to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr={req tag, index, 0};
  - on mem_ack: write mem_rdata into the victim way, set tag, valid=1, dirty=0;
  - if the victim came from the pointer, pointer = (pointer+1) mod WAYS;
  - go to LOOKUP; the repeat lookup hits and completes the access, so a store merges into the freshly filled line.
- mem_req drops for at least 1 cycle between WRITEBACK and FILL.
- mem_ack outside WRITEBACK/FILL is ignored.
- Multiple hitting ways must not occur; if they do, the lowest index wins.

Optional Feature:
- Macro ASSOC_CACHE_STATS_EN.
- When defined:
  - adds outputs hit_count, miss_count, wb_count (32 bits each, saturating at 0xFFFFFFFF, cleared by reset);
  - a LOOKUP hit of a first lookup increments hit_count; a LOOKUP miss increments miss_count;
  - the repeat lookup after a fill counts nothing;
  - each WRITEBACK mem_ack increments wb_count.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan (WAYS=2, SETS=4, WORDS_PER_LINE=4; set index=addr[5:4]):
- Cold load 0x104:
  - mem_req=1, mem_we=0, mem_addr=0x100;
  - ack with line words {0xA0,0xA1,0xA2,0xA3};
  - cpu_rdata=0xA1; a following load of 0x10C returns 0xA3 one cycle after acceptance, with no mem_req.
- Store hit at 0x100:
  - word 0x11223344, be=4'b0011, wdata=0xAABBCCDD;
  - then load 0x100 returns 0x1122CCDD; mem_req stays 0 throughout.
- Dirty eviction in set 0:
  - sequence: store 0x000 (word0=0xDEADBEEF), load 0x040, load 0x080;
  - WRITEBACK: mem_addr=0x000, mem_we=1, mem_wdata[31:0]=0xDEADBEEF;
  - then FILL at mem_addr=0x080.
- Replacement:
  - loads of 0x000 then 0x040 fill ways 0 and 1 (no eviction);
  - load 0x080 evicts way 0 (pointer 0 to 1);
  - load 0x0C0 evicts way 1.
- Reset in FILL:
  - rst_b=0 while mem_req=1 makes mem_req=0 next cycle; a late mem_ack is ignored;
  - load 0x100 afterwards misses (mem_req with mem_addr=0x100).
- With ASSOC_CACHE_STATS_EN: after the dirty-eviction scenario, hit_count=0, miss_count=3, wb_count=1.
